// File: rtl/systolic_affine_pe_pkg.sv
// Shared types, default scoring constants and saturating helpers for the affine-gap PE.
package design_variables;

    typedef enum logic [1:0] {IDLE, READY, RUN, DONE} pe_state_t;

    localparam int SOURCE_WIDTH = 2;
    typedef enum logic [SOURCE_WIDTH-1:0] {ZERO, DIAG, TOP, LEFT} src_t;

    localparam int DEFAULT_MATCH      = 2;
    localparam int DEFAULT_MISMATCH   = 1;
    localparam int DEFAULT_GAP_OPEN   = 3;
    localparam int DEFAULT_GAP_EXTEND = 1;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // Clamps to the all-ones value of a score that is `width` bits wide.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] sum;
        logic [32:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = (33'd1 << width) - 33'd1;
        return (sum > limit) ? limit[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/systolic_affine_pe_max3_src.sv
// Three-way maximum of the diagonal, top (F) and left (E) candidates with source encoding.
module max3_src
    import design_variables::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] t_i,
    input  logic [WIDTH-1:0] l_i,
    output logic [WIDTH-1:0] max_o,
    output src_t             src_o
);

    // Ties resolve diagonal first, then top, then left.
    always_comb begin
        logic [WIDTH-1:0] m;
        m = d_i;
        if (t_i > m) m = t_i;
        if (l_i > m) m = l_i;
        max_o = m;
        src_o = LEFT;
        if (m == '0)       src_o = ZERO;
        else if (d_i == m) src_o = DIAG;
        else if (t_i == m) src_o = TOP;
    end

endmodule

// File: rtl/systolic_affine_pe.sv
// Smith-Waterman systolic PE with Gotoh affine gaps and saturating scores.
// Define PE_TRACEBACK_EN to add the registered src_out traceback port.
module systolic_affine_pe
    import design_variables::*;
#(
    parameter int SCORE_WIDTH  = 16,
    parameter int LETTER_WIDTH = 2,
    parameter int COL_WIDTH    = 10,
    parameter int MATCH        = DEFAULT_MATCH,
    parameter int MISMATCH     = DEFAULT_MISMATCH,
    parameter int GAP_OPEN     = DEFAULT_GAP_OPEN,
    parameter int GAP_EXTEND   = DEFAULT_GAP_EXTEND
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    query_load,
    input  logic [LETTER_WIDTH-1:0] query_letter_in,
    input  logic                    db_valid_in,
    input  logic                    db_last_in,
    input  logic [LETTER_WIDTH-1:0] db_letter_in,
    input  logic [SCORE_WIDTH-1:0]  h_in,
    input  logic [SCORE_WIDTH-1:0]  f_in,
    output logic                    db_valid_out,
    output logic                    db_last_out,
    output logic [LETTER_WIDTH-1:0] db_letter_out,
    output logic [SCORE_WIDTH-1:0]  h_out,
    output logic [SCORE_WIDTH-1:0]  f_out,
    output logic [SCORE_WIDTH-1:0]  best_score,
    output logic [COL_WIDTH-1:0]    best_col,
    output logic                    done
`ifdef PE_TRACEBACK_EN
    ,
    output logic [SOURCE_WIDTH-1:0] src_out
`endif
);

    pe_state_t state_q, state_d;

    logic [LETTER_WIDTH-1:0] query_q;
    logic [SCORE_WIDTH-1:0]  h_left_q, e_left_q, h_diag_q;
    logic [SCORE_WIDTH-1:0]  h_out_q, f_out_q, best_score_q;
    logic [COL_WIDTH-1:0]    col_q, best_col_q;
    logic                    db_valid_q, db_last_q;
    logic [LETTER_WIDTH-1:0] db_letter_q;

    logic                   beat, newSeq;
    logic [SCORE_WIDTH-1:0] hLeftEff, eLeftEff, hDiagEff, bestEff;
    logic [COL_WIDTH-1:0]   colEff, bestColEff, colNext;
    logic [SCORE_WIDTH-1:0] eOpen, eExt, eVal, fOpen, fExt, fVal, dVal, hVal;
    src_t                   srcVal;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A valid beat in READY/DONE opens a sequence; a last beat always lands in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (query_load) state_d = READY;
            READY, DONE: begin
                if (db_valid_in)     state_d = db_last_in ? DONE : RUN;
                else if (query_load) state_d = READY;
            end
            RUN:   if (db_valid_in && db_last_in) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign beat   = db_valid_in && (state_q != IDLE);
    assign newSeq = db_valid_in && ((state_q == READY) || (state_q == DONE));

    always_comb begin
        hLeftEff   = newSeq ? '0 : h_left_q;
        eLeftEff   = newSeq ? '0 : e_left_q;
        hDiagEff   = newSeq ? '0 : h_diag_q;
        bestEff    = newSeq ? '0 : best_score_q;
        colEff     = newSeq ? '0 : col_q;
        bestColEff = newSeq ? '0 : best_col_q;
        colNext    = (colEff == {COL_WIDTH{1'b1}}) ? colEff : colEff + 1'b1;

        eOpen = SCORE_WIDTH'(sat_sub(32'(hLeftEff), 32'(GAP_OPEN)));
        eExt  = SCORE_WIDTH'(sat_sub(32'(eLeftEff), 32'(GAP_EXTEND)));
        eVal  = (eOpen > eExt) ? eOpen : eExt;
        fOpen = SCORE_WIDTH'(sat_sub(32'(h_in), 32'(GAP_OPEN)));
        fExt  = SCORE_WIDTH'(sat_sub(32'(f_in), 32'(GAP_EXTEND)));
        fVal  = (fOpen > fExt) ? fOpen : fExt;
        dVal  = (query_q == db_letter_in)
              ? SCORE_WIDTH'(sat_add(32'(hDiagEff), 32'(MATCH), SCORE_WIDTH))
              : SCORE_WIDTH'(sat_sub(32'(hDiagEff), 32'(MISMATCH)));
    end

    max3_src #(.WIDTH(SCORE_WIDTH)) u_max3 (
        .d_i   (dVal),
        .t_i   (fVal),
        .l_i   (eVal),
        .max_o (hVal),
        .src_o (srcVal)
    );

    // Pass-through registers run in every state; scoring state only moves on a processed beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            query_q      <= '0;
            h_left_q     <= '0;
            e_left_q     <= '0;
            h_diag_q     <= '0;
            h_out_q      <= '0;
            f_out_q      <= '0;
            best_score_q <= '0;
            best_col_q   <= '0;
            col_q        <= '0;
            db_valid_q   <= 1'b0;
            db_last_q    <= 1'b0;
            db_letter_q  <= '0;
        end else begin
            db_valid_q  <= db_valid_in;
            db_last_q   <= db_last_in;
            db_letter_q <= db_letter_in;
            if (query_load && (state_q != RUN)) query_q <= query_letter_in;
            if (beat) begin
                h_left_q <= hVal;
                e_left_q <= eVal;
                h_diag_q <= h_in;
                h_out_q  <= hVal;
                f_out_q  <= fVal;
                col_q    <= colNext;
                if (hVal > bestEff) begin
                    best_score_q <= hVal;
                    best_col_q   <= colEff;
                end else begin
                    best_score_q <= bestEff;
                    best_col_q   <= bestColEff;
                end
            end
        end
    end

`ifdef PE_TRACEBACK_EN
    src_t src_q;

    always_ff @(posedge clk) begin
        if (rst)       src_q <= ZERO;
        else if (beat) src_q <= srcVal;
    end

    assign src_out = src_q;
`else
    logic unusedSrc;
    assign unusedSrc = ^srcVal;
`endif

    assign db_valid_out  = db_valid_q;
    assign db_last_out   = db_last_q;
    assign db_letter_out = db_letter_q;
    assign h_out         = h_out_q;
    assign f_out         = f_out_q;
    assign best_score    = best_score_q;
    assign best_col      = best_col_q;
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_systolic_affine_pe.sv
// Directed bench for systolic_affine_pe with a cycle-level score model and hand-computed pins.
// Narrow SCORE_WIDTH/COL_WIDTH expose score and column saturation; honours PE_TRACEBACK_EN.
module tb_systolic_affine_pe;

    localparam int SW   = 4;
    localparam int LW   = 2;
    localparam int CW   = 3;
    localparam int SMAX = (1 << SW) - 1;
    localparam int CMAX = (1 << CW) - 1;
    localparam int A = 0, C = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          query_load = 1'b0;
    logic [LW-1:0] query_letter_in = '0;
    logic          db_valid_in = 1'b0;
    logic          db_last_in = 1'b0;
    logic [LW-1:0] db_letter_in = '0;
    logic [SW-1:0] h_in = '0;
    logic [SW-1:0] f_in = '0;
    logic          db_valid_out, db_last_out, done;
    logic [LW-1:0] db_letter_out;
    logic [SW-1:0] h_out, f_out, best_score;
    logic [CW-1:0] best_col;
`ifdef PE_TRACEBACK_EN
    logic [1:0]    src_out;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 ready, 2 run, 3 done.
    int mState, mQ, mHl, mEl, mHd, mCol, mBest, mBestCol, mHout, mFout, mSrc;
    int mDv, mDl, mDlet;
    int gapH[4];
    int plainH[4];

    systolic_affine_pe #(.SCORE_WIDTH(SW), .LETTER_WIDTH(LW), .COL_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .query_load      (query_load),
        .query_letter_in (query_letter_in),
        .db_valid_in     (db_valid_in),
        .db_last_in      (db_last_in),
        .db_letter_in    (db_letter_in),
        .h_in            (h_in),
        .f_in            (f_in),
        .db_valid_out    (db_valid_out),
        .db_last_out     (db_last_out),
        .db_letter_out   (db_letter_out),
        .h_out           (h_out),
        .f_out           (f_out),
        .best_score      (best_score),
        .best_col        (best_col),
        .done            (done)
`ifdef PE_TRACEBACK_EN
        ,
        .src_out         (src_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic int subSat(int a, int b);
        return (a > b) ? a - b : 0;
    endfunction

    function automatic int addSat(int a, int b);
        return (a + b > SMAX) ? SMAX : a + b;
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input int r, input int ql, input int qlet, input int v,
                             input int last, input int dlet, input int hin, input int fin);
        int e, f, d, h, nxt;
        if (r != 0) begin
            mState = 0; mQ = 0; mHl = 0; mEl = 0; mHd = 0; mCol = 0;
            mBest = 0; mBestCol = 0; mHout = 0; mFout = 0; mSrc = 0;
            mDv = 0; mDl = 0; mDlet = 0;
            return;
        end
        mDv = v; mDl = last; mDlet = dlet;
        if (v != 0 && mState != 0) begin
            if (mState == 1 || mState == 3) begin
                mHl = 0; mEl = 0; mHd = 0; mCol = 0; mBest = 0; mBestCol = 0;
            end
            e = max2(subSat(mHl, 3), subSat(mEl, 1));
            f = max2(subSat(hin, 3), subSat(fin, 1));
            d = (mQ == dlet) ? addSat(mHd, 2) : subSat(mHd, 1);
            h = max2(d, max2(e, f));
            mSrc = (h == 0) ? 0 : (d == h) ? 1 : (f == h) ? 2 : 3;
            if (h > mBest) begin
                mBest = h;
                mBestCol = mCol;
            end
            mHl = h; mEl = e; mHd = hin; mHout = h; mFout = f;
            mCol = (mCol < CMAX) ? mCol + 1 : CMAX;
        end
        if (ql != 0 && mState != 2) mQ = qlet;
        nxt = mState;
        case (mState)
            0: if (ql != 0) nxt = 1;
            1, 3: if (v != 0) nxt = (last != 0) ? 3 : 2;
                  else if (ql != 0) nxt = 1;
            2: if (v != 0 && last != 0) nxt = 3;
            default: nxt = 0;
        endcase
        mState = nxt;
    endtask

    task automatic checkOutput();
        check("db_valid_out", 32'(db_valid_out), mDv);
        check("db_last_out", 32'(db_last_out), mDl);
        check("db_letter_out", 32'(db_letter_out), mDlet);
        check("h_out", 32'(h_out), mHout);
        check("f_out", 32'(f_out), mFout);
        check("best_score", 32'(best_score), mBest);
        check("best_col", 32'(best_col), mBestCol);
        check("done", 32'(done), (mState == 3) ? 1 : 0);
`ifdef PE_TRACEBACK_EN
        check("src_out", 32'(src_out), mSrc);
`endif
    endtask

    task automatic applyStimulus(input int r, input int ql, input int qlet, input int v,
                                 input int last, input int dlet, input int hin, input int fin);
        rst             = (r != 0);
        query_load      = (ql != 0);
        query_letter_in = LW'(qlet);
        db_valid_in     = (v != 0);
        db_last_in      = (last != 0);
        db_letter_in    = LW'(dlet);
        h_in            = SW'(hin);
        f_in            = SW'(fin);
        modelStep(r, ql, qlet, v, last, dlet, hin, fin);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runGapSeq(input int withGap);
        applyStimulus(0, 0, 0, 1, 0, A, 4, 0);
        if (withGap != 0) gapH[0] = int'(h_out); else plainH[0] = int'(h_out);
        applyStimulus(0, 0, 0, 1, 0, C, 3, 2);
        if (withGap != 0) gapH[1] = int'(h_out); else plainH[1] = int'(h_out);
        if (withGap != 0) begin
            for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 2, 9, 9);
            check("gap_hold_h", 32'(h_out), 32'(gapH[1]));
        end
        applyStimulus(0, 0, 0, 1, 0, A, 5, 1);
        if (withGap != 0) gapH[2] = int'(h_out); else plainH[2] = int'(h_out);
        applyStimulus(0, 0, 0, 1, 1, A, 0, 0);
        if (withGap != 0) gapH[3] = int'(h_out); else plainH[3] = int'(h_out);
    endtask

    initial begin
        // Reset with a query load and a beat present: everything stays zero.
        applyStimulus(1, 1, 0, 1, 0, 2, 5, 5);
        applyStimulus(1, 1, 0, 1, 0, 2, 5, 5);
        check("rst_h_out", 32'(h_out), 0);
        check("rst_db_valid", 32'(db_valid_out), 0);

        // IDLE forwards beats without scoring.
        applyStimulus(0, 0, 0, 1, 0, 3, 5, 5);
        check("idle_fwd_letter", 32'(db_letter_out), 3);
        check("idle_h_out", 32'(h_out), 0);

        // q=A, db=A,C,A; a query_load during RUN must be ignored.
        applyStimulus(0, 1, A, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, A, 0, 0);
        check("t1_h0", 32'(h_out), 2);
`ifdef PE_TRACEBACK_EN
        check("t1_src_diag", 32'(src_out), 1);
`endif
        applyStimulus(0, 1, 3, 1, 0, C, 0, 0);
        check("t1_h1", 32'(h_out), 0);
        applyStimulus(0, 0, 0, 1, 1, A, 0, 0);
        check("t1_h2", 32'(h_out), 2);
        check("t1_best", 32'(best_score), 2);
        check("t1_best_col", 32'(best_col), 0);
        check("t1_done", 32'(done), 1);

        // Vertical gap: open from h_in=10, then extend from f_in=7.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, A, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, C, 10, 0);
        check("t2_f0", 32'(f_out), 7);
        check("t2_h0", 32'(h_out), 7);
        applyStimulus(0, 0, 0, 1, 1, C, 0, 7);
        check("t2_f1", 32'(f_out), 6);
        check("t2_h1", 32'(h_out), 9);

        // Diagonal saturation at all-ones, then mismatch clamping at zero.
        applyStimulus(0, 0, 0, 1, 0, A, 15, 0);
        check("t3_h0", 32'(h_out), 12);
        applyStimulus(0, 0, 0, 1, 1, A, 0, 0);
        check("t3_sat", 32'(h_out), 15);
        applyStimulus(0, 0, 0, 1, 0, C, 2, 0);
        check("t3_clamp", 32'(h_out), 0);
        applyStimulus(0, 0, 0, 1, 1, C, 0, 0);
        check("t3_h1", 32'(h_out), 1);

        // Rising diagonal over 10 columns: column counter saturates.
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 1, (k == 9) ? 1 : 0, A, k, 0);
        check("t4_best", 32'(best_score), 10);
        check("t4_best_col_sat", 32'(best_col), 7);

        // Same sequence with and without a 3-cycle bubble, back to back.
        runGapSeq(1);
        runGapSeq(0);
        for (int i = 0; i < 4; i++) check("gap_vs_plain", 32'(gapH[i]), 32'(plainH[i]));
        applyStimulus(0, 0, 0, 1, 0, A, 0, 0);
        check("b2b_col_restart", 32'(best_col), 0);
        check("b2b_h0", 32'(h_out), 2);

        // Reset mid-run returns to IDLE; beats pass but are not scored.
        applyStimulus(1, 0, 0, 1, 0, A, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, A, 7, 7);
        check("midrst_h_out", 32'(h_out), 0);
        check("midrst_done", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
